// File: rtl/pipe_ctrl_decoder.sv
// Pipelined main control: decodes the ID opcode and carries controls through EX/MEM/WB with valid bits.
// Latency ID->EX 1, ->MEM 2, ->WB 3 cycles; load-use hazards hold ID for one cycle and insert an EX bubble.
module pipe_ctrl_decoder #(
  parameter int OP_W      = 6,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter bit LU_DET_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [OP_W-1:0]  instr_op_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [1:0]       ex_alu_op_o,
  output logic             ex_alusrc_o,
  output logic [1:0]       ex_regdst_o,
  output logic [1:0]       ex_branch_o,
  output logic             ex_jump_o,
  output logic             ex_illegal_o,
  output logic [REG_W-1:0] ex_rt_o,
  output logic             mem_valid_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             wb_valid_o,
  output logic             wb_regwrite_o,
  output logic [1:0]       wb_memtoreg_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b101100);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000110);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000111);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alusrc;
    logic [1:0] regdst;
    logic [1:0] branch;
    logic       jump;
    logic       illegal;
    logic       mread;
    logic       mwrite;
    logic       regwrite;
    logic [1:0] memtoreg;
  } ctrl_t;

  ctrl_t            dec;
  logic             uses_rs;
  logic             uses_rt;
  ctrl_t            ex_ctrl;
  logic             ex_valid;
  logic [REG_W-1:0] ex_rt;
  logic             mem_valid;
  logic             mem_read;
  logic             mem_write;
  logic             mem_regwrite;
  logic [1:0]       mem_memtoreg;
  logic             wb_valid;
  logic             wb_regwrite;
  logic [1:0]       wb_memtoreg;
  logic [CNT_W-1:0] stall_cnt;
  logic             hazard;

  always_comb begin
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (instr_op_i)
      OP_R: begin
        dec.alu_op = 2'b10; dec.regdst = 2'b01; dec.regwrite = 1'b1;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec.alusrc = 1'b1; dec.regwrite = 1'b1;
        uses_rs = 1'b1;
      end
      OP_LW: begin
        dec.alusrc = 1'b1; dec.mread = 1'b1; dec.regwrite = 1'b1; dec.memtoreg = 2'b01;
        uses_rs = 1'b1;
      end
      OP_SW: begin
        dec.alusrc = 1'b1; dec.mwrite = 1'b1;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = 2'b01; dec.branch = 2'b01;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op = 2'b01; dec.branch = 2'b10;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_JAL: begin
        dec.regdst = 2'b10; dec.jump = 1'b1; dec.regwrite = 1'b1; dec.memtoreg = 2'b10;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Only lw sets mread, so it identifies a load sitting in EX.
  assign hazard = LU_DET_EN && ex_valid && ex_ctrl.mread && (ex_rt != '0) && id_valid_i &&
                  ((uses_rs && (ex_rt == id_rs_i)) || (uses_rt && (ex_rt == id_rt_i)));
  assign stall_o = hazard && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_rt        <= '0;
      mem_valid    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 2'b00;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 2'b00;
      stall_cnt    <= '0;
    end else begin
      if (flush_i || stall_o || !id_valid_i) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rt    <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= dec;
        ex_rt    <= id_rt_i;
      end
      mem_valid    <= ex_valid;
      mem_read     <= ex_ctrl.mread;
      mem_write    <= ex_ctrl.mwrite;
      mem_regwrite <= ex_ctrl.regwrite;
      mem_memtoreg <= ex_ctrl.memtoreg;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      if (stall_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid_o    = ex_valid;
  assign ex_alu_op_o   = ex_ctrl.alu_op;
  assign ex_alusrc_o   = ex_ctrl.alusrc;
  assign ex_regdst_o   = ex_ctrl.regdst;
  assign ex_branch_o   = ex_ctrl.branch;
  assign ex_jump_o     = ex_ctrl.jump;
  assign ex_illegal_o  = ex_ctrl.illegal;
  assign ex_rt_o       = ex_rt;
  assign mem_valid_o   = mem_valid;
  assign mem_read_o    = mem_read;
  assign mem_write_o   = mem_write;
  assign wb_valid_o    = wb_valid;
  assign wb_regwrite_o = wb_regwrite;
  assign wb_memtoreg_o = wb_memtoreg;
  assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed bench for pipe_ctrl_decoder with a 2-bit stall counter so saturation is reachable.
module tb_pipe_ctrl_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [5:0] instr_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       flush;
  logic       stall;
  logic       ex_valid;
  logic [1:0] ex_alu_op;
  logic       ex_alusrc;
  logic [1:0] ex_regdst;
  logic [1:0] ex_branch;
  logic       ex_jump;
  logic       ex_illegal;
  logic [4:0] ex_rt;
  logic       mem_valid;
  logic       mem_read;
  logic       mem_write;
  logic       wb_valid;
  logic       wb_regwrite;
  logic [1:0] wb_memtoreg;
  logic [1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_decoder #(.OP_W(6), .REG_W(5), .CNT_W(2), .LU_DET_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .instr_op_i(instr_op),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .flush_i(flush), .stall_o(stall),
    .ex_valid_o(ex_valid), .ex_alu_op_o(ex_alu_op), .ex_alusrc_o(ex_alusrc),
    .ex_regdst_o(ex_regdst), .ex_branch_o(ex_branch), .ex_jump_o(ex_jump),
    .ex_illegal_o(ex_illegal), .ex_rt_o(ex_rt), .mem_valid_o(mem_valid),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .wb_valid_o(wb_valid),
    .wb_regwrite_o(wb_regwrite), .wb_memtoreg_o(wb_memtoreg), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [9:0]  ex_vec;
  logic [2:0]  mem_vec;
  logic [3:0]  wb_vec;
  logic [24:0] all_out;
  assign ex_vec  = {ex_valid, ex_alu_op, ex_alusrc, ex_regdst, ex_branch, ex_jump, ex_illegal};
  assign mem_vec = {mem_valid, mem_read, mem_write};
  assign wb_vec  = {wb_valid, wb_regwrite, wb_memtoreg};
  assign all_out = {stall, ex_vec, ex_rt, mem_vec, wb_vec, stall_cnt};

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001001, LW = 6'b101100, SW = 6'b100100;
  localparam logic [5:0] BEQ = 6'b000110, BNE = 6'b000101, J = 6'b000111, JAL = 6'b000011;

  // Hand-computed expectations: EX {valid,aluop,alusrc,regdst,branch,jump,illegal},
  // MEM {valid,read,write}, WB {valid,regwrite,memtoreg}.
  logic [5:0] ops  [9] = '{R, ADDI, LW, SW, BEQ, BNE, J, JAL, 6'b111111};
  logic [9:0] exp_ex[9] = '{10'b1_10_0_01_00_0_0, 10'b1_00_1_00_00_0_0, 10'b1_00_1_00_00_0_0,
                            10'b1_00_1_00_00_0_0, 10'b1_01_0_00_01_0_0, 10'b1_01_0_00_10_0_0,
                            10'b1_00_0_00_00_1_0, 10'b1_00_0_10_00_1_0, 10'b1_00_0_00_00_0_1};
  logic [2:0] exp_mem[9] = '{3'b100, 3'b100, 3'b110, 3'b101, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [3:0] exp_wb [9] = '{4'b1100, 4'b1100, 4'b1101, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1110, 4'b1000};
  logic [5:0] cons_op[5] = '{R, SW, BEQ, BNE, ADDI};
  logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    id_valid = v; instr_op = op; id_rs = rs; id_rt = rt; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_all", 32'(all_out), 32'd0);
    rst = 1'b0;

    // Decode of every opcode, followed through MEM and WB
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, ops[i], 5'd0, 5'(i + 1), 1'b0);
      tick;
      chk($sformatf("dec_ex_%0d", i), 32'(ex_vec), 32'(exp_ex[i]));
      chk($sformatf("dec_rt_%0d", i), 32'(ex_rt), 32'(i + 1));
      drive(1'b0, R, 5'd0, 5'd0, 1'b0);
      tick;
      chk($sformatf("dec_mem_%0d", i), 32'(mem_vec), 32'(exp_mem[i]));
      tick;
      chk($sformatf("dec_wb_%0d", i), 32'(wb_vec), 32'(exp_wb[i]));
    end
    chk("cnt_after_decode", 32'(stall_cnt), 32'd0);

    // Load-use: one stall, one bubble, then the held add issues
    drive(1'b1, LW, 5'd1, 5'd5, 1'b0);
    tick;
    drive(1'b1, R, 5'd5, 5'd2, 1'b0);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    tick;
    chk("lu_bubble_ex", 32'(ex_vec), 32'd0);
    chk("lu_bubble_rt", 32'(ex_rt), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_stall_released", 32'(stall), 32'd0);
    chk("lu_mem_lw", 32'(mem_vec), 32'b110);
    tick;
    chk("lu_issue_ex", 32'(ex_vec), 32'(exp_ex[0]));
    chk("lu_issue_rt", 32'(ex_rt), 32'd2);

    // No-hazard cases
    drive(1'b1, LW, 5'd1, 5'd0, 1'b0);
    tick;
    drive(1'b1, R, 5'd0, 5'd0, 1'b0);
    #1 chk("nohaz_rt0", 32'(stall), 32'd0);
    drive(1'b1, LW, 5'd1, 5'd5, 1'b0);
    tick;
    drive(1'b1, J, 5'd5, 5'd5, 1'b0);
    #1 chk("nohaz_j", 32'(stall), 32'd0);
    tick;
    chk("nohaz_j_ex", 32'(ex_vec), 32'(exp_ex[6]));
    drive(1'b1, LW, 5'd1, 5'd5, 1'b0);
    tick;
    drive(1'b0, R, 5'd5, 5'd5, 1'b0);
    #1 chk("nohaz_idinvalid", 32'(stall), 32'd0);
    tick;
    chk("nohaz_cnt", 32'(stall_cnt), 32'd1);

    // Flush beats stall
    drive(1'b1, LW, 5'd1, 5'd5, 1'b0);
    tick;
    drive(1'b1, R, 5'd5, 5'd3, 1'b1);
    #1 chk("flush_stall", 32'(stall), 32'd0);
    tick;
    chk("flush_ex", 32'(ex_vec), 32'd0);
    chk("flush_cnt", 32'(stall_cnt), 32'd1);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, LW, 5'd1, 5'd6, 1'b0);
    tick;
    drive(1'b1, SW, 5'd1, 5'd6, 1'b0);
    #1 chk("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1 chk("mid_rst_all", 32'(all_out), 32'd0);
    tick;
    chk("mid_rst_hold", 32'(all_out), 32'd0);
    rst = 1'b0;
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    tick;

    // Five load-use pairs drive the 2-bit counter into saturation
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, LW, 5'd0, 5'(k + 1), 1'b0);
      tick;
      if (k == 1 || k == 3) drive(1'b1, cons_op[k], 5'd0, 5'(k + 1), 1'b0);
      else drive(1'b1, cons_op[k], 5'(k + 1), 5'd0, 1'b0);
      #1 chk($sformatf("sat_stall_%0d", k), 32'(stall), 32'd1);
      tick;
      chk($sformatf("sat_cnt_%0d", k), 32'(stall_cnt), 32'(exp_cnt[k]));
      chk($sformatf("sat_bubble_%0d", k), 32'(ex_valid), 32'd0);
      tick;
      chk($sformatf("sat_issue_%0d", k), 32'(ex_valid), 32'd1);
    end
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    repeat (3) tick;
    chk("sat_hold", 32'(stall_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
